// File: rtl/riscv_multicycle_controller_if.sv
// Control bundle between the multi-cycle RISC-V controller and its datapath.
// The master side is the datapath, which supplies the instruction fields and flags. The slave side is the controller.
interface riscv_multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               Zero;
  logic               SF;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ImmSrc;
  logic [2:0]         ALUControl;
  logic [STATE_W-1:0] state;

  modport master (
    output op, funct3, funct7b5, Zero, SF,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
  );

  modport slave (
    input  op, funct3, funct7b5, Zero, SF,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
  );
endinterface

// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RISC-V main FSM and ALU decoder. Defining BRANCH_UNSIGNED_EN
// enables bltu/bgeu. When it is undefined, those branches are never taken.
module riscv_multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  riscv_multicycle_controller_if.slave  bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       branch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl_reg;
  logic   taken;
  logic [2:0] alu_control;
  logic [1:0] imm_src;

  // Moore outputs are registered from the next state, so they line up with state_reg.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write = 1'b1;  c.pc_write   = 1'b1;
        c.alu_src_b = 2'b10; c.result_src = 2'b10; c.alu_op = ALUOP_ADD;
      end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.alu_op = ALUOP_ADD; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = ALUOP_ADD; end
      MEMREAD:  begin c.adr_src = 1'b1; c.result_src = 2'b00; end
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.result_src = 2'b00; c.mem_write = 1'b1; end
      EXECR:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_op = ALUOP_FUNCT; end
      EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = ALUOP_FUNCT; end
      ALUWB:    begin c.result_src = 2'b00; c.reg_write = 1'b1; end
      BRANCH: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_op = ALUOP_SUB;
        c.result_src = 2'b00; c.branch = 1'b1;
      end
      JAL: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = ALUOP_ADD;
        c.result_src = 2'b00; c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_B:         state_next = BRANCH;
          OP_JAL:       state_next = JAL;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = MEMWB;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      JAL:      state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= FETCH;
      ctrl_reg  <= decode_ctrl(FETCH);
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= decode_ctrl(state_next);
    end
  end

  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000: taken = bus.Zero;
      3'b001: taken = ~bus.Zero;
`ifdef BRANCH_UNSIGNED_EN
      3'b110: taken = bus.SF;
      3'b111: taken = ~bus.SF;
`endif
      default: taken = 1'b0;
    endcase
  end

`ifndef BRANCH_UNSIGNED_EN
  logic unused_sf;
  assign unused_sf = bus.SF;
`endif

  always_comb begin
    alu_control = 3'b000;
    case (ctrl_reg.alu_op)
      ALUOP_SUB: alu_control = 3'b001;
      ALUOP_FUNCT: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.op == OP_R && bus.funct7b5) ? 3'b001 : 3'b000;
          3'b001:  alu_control = 3'b110;
          3'b010:  alu_control = 3'b101;
          3'b011:  alu_control = 3'b101;
          3'b100:  alu_control = 3'b100;
          3'b101:  alu_control = 3'b111;
          3'b110:  alu_control = 3'b011;
          default: alu_control = 3'b010;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_B:    imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Write enables are gated by reset_n directly, so an asserted reset suppresses writes in the same cycle.
  assign bus.PCWrite    = reset_n & (ctrl_reg.pc_write | (ctrl_reg.branch & taken));
  assign bus.MemWrite   = reset_n & ctrl_reg.mem_write;
  assign bus.IRWrite    = reset_n & ctrl_reg.ir_write;
  assign bus.RegWrite   = reset_n & ctrl_reg.reg_write;
  assign bus.AdrSrc     = ctrl_reg.adr_src;
  assign bus.ResultSrc  = ctrl_reg.result_src;
  assign bus.ALUSrcA    = ctrl_reg.alu_src_a;
  assign bus.ALUSrcB    = ctrl_reg.alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_control;
  assign bus.state      = STATE_W'(state_reg);
endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench for riscv_multicycle_controller. The stimulus pushes one expected
// control vector per cycle, and the negedge monitor pops each vector and compares it.
module tb_riscv_multicycle_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  riscv_multicycle_controller_if #(.STATE_W(4)) bus ();

  riscv_multicycle_controller #(.STATE_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef BRANCH_UNSIGNED_EN
  localparam logic UNS = 1'b1;
`else
  localparam logic UNS = 1'b0;
`endif

  // Vector fields: {state, PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}.
  logic [19:0] exp_q [$];
  string       name_q [$];
  int          tests = 0;
  int          fails = 0;
  logic [19:0] exp_v;
  logic [19:0] got_v;
  string       cur_name;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v    = exp_q.pop_front();
      cur_name = name_q.pop_front();
      got_v = {bus.state, bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.AdrSrc,
               bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl};
      tests++;
      if (got_v !== exp_v)
        begin
          fails++;
          $display("[TB] FAIL %s: got %b required %b", cur_name, got_v, exp_v);
        end
      else
        $display("[TB] ok   %s: %b", cur_name, got_v);
    end
  end

  task automatic cyc(input string nm, input logic [3:0] st,
                     input logic pcw, input logic memw, input logic irw, input logic regw,
                     input logic adr, input logic [1:0] rs, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [1:0] imm, input logic [2:0] alu);
    exp_q.push_back({st, pcw, memw, irw, regw, adr, rs, sa, sb, imm, alu});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic s);
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z; bus.SF = s;
  endtask

  task automatic fetch_decode(input string nm, input logic [1:0] imm);
    cyc({nm, "_fetch"},  4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000);
    cyc({nm, "_decode"}, 4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000);
  endtask

  logic [2:0] i_alu [0:7];
  logic [2:0] r_f3  [0:3];
  logic       r_f7  [0:3];
  logic [2:0] r_alu [0:3];
  logic [2:0] b_f3  [0:8];
  logic       b_z   [0:8];
  logic       b_sf  [0:8];
  logic       b_pcw [0:8];

  initial begin
    i_alu = '{3'b000, 3'b110, 3'b101, 3'b101, 3'b100, 3'b111, 3'b011, 3'b010};
    r_f3  = '{3'b000, 3'b000, 3'b111, 3'b001};
    r_f7  = '{1'b1, 1'b0, 1'b0, 1'b0};
    r_alu = '{3'b001, 3'b000, 3'b010, 3'b110};
    b_f3  = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b110, 3'b110, 3'b111, 3'b111};
    b_z   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    b_sf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    b_pcw = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, UNS, 1'b0, UNS, 1'b0};

    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      cyc($sformatf("reset_%0d", k), 4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);

    // lw
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    fetch_decode("lw", 2'b00);
    cyc("lw_memadr",  4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    cyc("lw_memread", 4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    cyc("lw_memwb",   4'd4, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);

    // sw
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    fetch_decode("sw", 2'b01);
    cyc("sw_memadr",   4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    cyc("sw_memwrite", 4'd5, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);

    // R-type
    for (int k = 0; k < 4; k++) begin
      set_instr(7'b0110011, r_f3[k], r_f7[k], 1'b0, 1'b0);
      fetch_decode($sformatf("r%0d", k), 2'b00);
      cyc($sformatf("r%0d_execr", k), 4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, r_alu[k]);
      cyc($sformatf("r%0d_aluwb", k), 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    end

    // I-type, funct7b5 held high: the I-type decode must still never subtract.
    for (int k = 0; k < 8; k++) begin
      set_instr(7'b0010011, 3'(k), 1'b1, 1'b0, 1'b0);
      fetch_decode($sformatf("i_f3_%0d", k), 2'b00);
      cyc($sformatf("i_f3_%0d_execi", k), 4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, i_alu[k]);
      cyc($sformatf("i_f3_%0d_aluwb", k), 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    end

    // Branches
    for (int k = 0; k < 9; k++) begin
      set_instr(7'b1100011, b_f3[k], 1'b0, b_z[k], b_sf[k]);
      fetch_decode($sformatf("br%0d", k), 2'b10);
      cyc($sformatf("br%0d_f3_%b_z%0d_sf%0d", k, b_f3[k], b_z[k], b_sf[k]), 4'd9,
          b_pcw[k], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    end

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
    fetch_decode("jal", 2'b11);
    cyc("jal_jal",   4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000);
    cyc("jal_aluwb", 4'd8,  0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);

    // Illegal opcode: DECODE returns straight to FETCH.
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
    fetch_decode("illegal", 2'b00);

    // Reset asserted in MEMWRITE abandons the store.
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    fetch_decode("swrst", 2'b01);
    cyc("swrst_memadr", 4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    reset_n = 1'b0;
    cyc("swrst_memwrite_in_reset", 4'd5, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
    cyc("swrst_after_reset",       4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
    reset_n = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
    fetch_decode("post_reset", 2'b00);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Main control FSM plus ALU decoder for the multi-cycle RISC-V datapath.
- Consumes opcode/funct fields from the instruction register and the ALU's Zero/SF flags.
- Sequences fetch/decode/execute/memory/writeback and drives every datapath enable and mux select.
- Produces the 3-bit ALUControl consumed by the ALU.

Parameters:
STATE_W, 4, width of the state debug output (must be >= 4)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous reset, active-low
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU result-is-zero flag
SF  in  1  ALU flag, SrcB > SrcA unsigned
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  3  ALU operation
state  out  STATE_W  current state (debug)

Behaviour:
Clocking and reset:
- Single clk, synchronous active-low reset_n.
- While reset_n = 0: state loads FETCH (0) at each edge, and PCWrite, MemWrite, IRWrite and RegWrite are forced to 0 combinationally.
- Reset asserted mid-instruction abandons the instruction; no further writes occur.
- First fetch happens on the first edge after reset_n rises.

State encodings and transitions:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10.
- Encodings 11-15 are illegal and go to FETCH.
- FETCH -> DECODE.
- DECODE -> by op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other op -> FETCH, with no write in between
- MEMADR -> MEMREAD if op = lw, otherwise MEMWRITE.
- MEMREAD -> MEMWB -> FETCH.
- MEMWRITE -> FETCH.
- EXECR and EXECI -> ALUWB -> FETCH.
- BRANCH -> FETCH.
- JAL -> ALUWB.
- Cycle counts: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4.

Outputs (Moore, decoded from state; unlisted outputs are 0):
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (precompute branch/jal target).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct.
- ALUWB: ResultSrc=00, RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, PCWrite=taken (the only Mealy term).
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCWrite=1.

ImmSrc (combinational from op, in every state):
- sw -> 01, branch -> 10, jal -> 11, all other op -> 00.

ALUControl:
- ALUOp add -> 000; ALUOp sub -> 001.
- ALUOp funct, decoded by funct3:
  - 000 -> 001 if (op = 0110011 and funct7b5 = 1), else 000 (I-type never subtracts)
  - 001 -> 110
  - 010 -> 101
  - 011 -> 101
  - 100 -> 100
  - 101 -> 111 (sra/srai execute as srl)
  - 110 -> 011
  - 111 -> 010

Branch taken:
- funct3 000: taken = Zero.
- funct3 001: taken = ~Zero.
- All other funct3: not taken, unless the optional feature is enabled.

Optional Feature:
- Macro: BRANCH_UNSIGNED_EN.
- Defined: in BRANCH, funct3 110 (bltu) takes when SF = 1, and funct3 111 (bgeu) takes when SF = 0. SF during the subtract equals rs2 > rs1 unsigned.
- Undefined: funct3 110 and 111 are never taken; the instruction still spends 3 cycles and returns to FETCH.

Test Plan:
- Hold reset_n = 0 for 3 cycles with op = 0110011 -> state = 0; PCWrite, MemWrite, IRWrite, RegWrite all 0. Release -> FETCH: IRWrite = 1, PCWrite = 1, ALUSrcB = 10, ALUControl = 000.
- lw (op 0000011) -> states 0, 1, 2, 3, 4, 0. MEMREAD: AdrSrc = 1. MEMWB: ResultSrc = 01, RegWrite = 1. ImmSrc = 00 throughout.
- R-type sub (op 0110011, funct3 000, funct7b5 1) -> EXECR ALUControl = 001. Same with op 0010011 -> EXECI ALUControl = 000. funct3 111 -> 010; funct3 001 -> 110.
- beq with Zero = 1 -> BRANCH: PCWrite = 1, ALUControl = 001, ImmSrc = 10. bne with Zero = 1 -> PCWrite = 0; next state FETCH.
- jal (op 1101111) -> states 0, 1, 10, 8, 0. JAL: PCWrite = 1, ALUSrcA = 01, ALUSrcB = 10. ALUWB: RegWrite = 1.
- Illegal op 1111111 -> DECODE then FETCH, with no RegWrite or MemWrite. bltu with SF = 1 -> PCWrite = 1 only when BRANCH_UNSIGNED_EN is defined; reset_n = 0 in MEMWRITE -> MemWrite = 0 that cycle and state = 0 next.
